huff_freq_count: RTL and testbench

Histogram front end of the Huffman encoder. Counts occurrences of each 4-bit symbol over one input block. At block end, it emits one 8-bit node per symbol, packed as {weight[7:4], symbol[3:0]}, on a valid/ready stream. The node-sorting stage consumes this stream directly: it orders nodes by weight[7:4] before tree building.

---
 rtl/huff_pkg.sv | 29 ++
 rtl/huff_freq_count_if.sv | 29 ++
 rtl/huff_next_bin.sv | 45 ++++
 rtl/huff_freq_count.sv | 151 +++++++++++++++
 tb/tb_huff_freq_count.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/huff_pkg.sv
// Shared Huffman package: widths, node field helpers and the histogram
// state enum. Used by the frequency counter and the later sorting stages.
package huff_pkg;

    localparam int SYM_W    = 4;
    localparam int CNT_W    = 4;
    localparam int NODE_W   = CNT_W + SYM_W;
    localparam int NUM_BINS = 1 << SYM_W;

    typedef enum logic {
        COUNT = 1'b0,
        EMIT  = 1'b1
    } huff_state_t;

    // A node is {weight, symbol}; sorting orders on the weight field.
    function automatic logic [CNT_W-1:0] node_weight(input logic [NODE_W-1:0] n);
        return n[NODE_W-1:SYM_W];
    endfunction

    function automatic logic [SYM_W-1:0] node_symbol(input logic [NODE_W-1:0] n);
        return n[SYM_W-1:0];
    endfunction

    function automatic logic [NODE_W-1:0] make_node(input logic [CNT_W-1:0] w,
                                                    input logic [SYM_W-1:0] s);
        return {w, s};
    endfunction

endpackage

// File: rtl/huff_freq_count_if.sv
// Sample-in / node-out stream bundle of the Huffman histogram stage.
// master = producer of samples and consumer of nodes; slave = the counter.
interface huff_freq_count_if #(
    parameter int SYM_W = 4,
    parameter int CNT_W = 4
);

    logic                     in_valid;
    logic                     in_ready;
    logic [SYM_W-1:0]         in_sym;
    logic                     in_last;

    logic                     node_valid;
    logic                     node_ready;
    logic [CNT_W+SYM_W-1:0]   node;
    logic                     node_last;
    logic [SYM_W:0]           node_cnt;

    modport master (
        output in_valid, in_sym, in_last, node_ready,
        input  in_ready, node_valid, node, node_last, node_cnt
    );

    modport slave (
        input  in_valid, in_sym, in_last, node_ready,
        output in_ready, node_valid, node, node_last, node_cnt
    );

endinterface

// File: rtl/huff_next_bin.sv
// Combinational priority finder: lowest set mask bit at or above ptr.
// none_after is high when no other candidate lies above the found index.
// ptr is one bit wider than an index so "past the last bin" is encodable.
module huff_next_bin #(
    parameter int SYM_W = 4
) (
    input  logic [(1<<SYM_W)-1:0] mask,
    input  logic [SYM_W:0]        ptr,
    output logic [SYM_W-1:0]      idx,
    output logic                  found,
    output logic                  none_after
);

    localparam int BINS = 1 << SYM_W;

    logic [BINS-1:0] window;
    logic [BINS-1:0] cand;
    logic [BINS-1:0] upper;

    // Window of bins at or above the scan pointer
    generate
        for (genvar gi = 0; gi < BINS; gi++) begin : g_window
            assign window[gi] = ((SYM_W+1)'(gi) >= ptr);
        end
    endgenerate

    assign cand = mask & window;

    // Clearing the lowest candidate leaves only those above the chosen one
    assign upper      = cand & (cand - BINS'(1));
    assign none_after = (upper == '0);

    // Lowest-index candidate wins (descending loop, last hit overwrites)
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = BINS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx   = SYM_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/huff_freq_count.sv
// Huffman histogram front end: counts 4-bit symbols over a block, then
// streams one {weight, symbol} node per bin in ascending symbol order.
// Optional feature macro: HUFF_SKIP_ZERO_EN -- when defined, bins whose
// weight is zero are not emitted; otherwise all bins are emitted.
module huff_freq_count #(
    parameter int SYM_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    huff_freq_count_if.slave bus
);

    import huff_pkg::*;

    localparam int BIN_N    = 1 << SYM_W;
    localparam int NODE_BITS = CNT_W + SYM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    huff_state_t state_reg;
    huff_state_t state_next;

    // Bin storage, flattened from the per-bin registers below
    logic [BIN_N-1:0][CNT_W-1:0] bin_w;
    logic [BIN_N-1:0]            mask_w;

    logic [SYM_W:0]              ptr_reg;
    logic [NODE_BITS-1:0]        node_reg;
    logic                        node_valid_reg;
    logic                        node_last_reg;
    logic [SYM_W:0]              node_cnt_reg;

    logic                        in_fire;
    logic                        node_fire;
    logic                        block_done;
    logic                        load_node;

    logic [BIN_N-1:0]            scan_mask;
    logic [SYM_W-1:0]            next_idx;
    logic                        next_found;
    logic                        next_none_after;

`ifdef HUFF_SKIP_ZERO_EN
    assign scan_mask = mask_w;
`else
    // Every bin is emittable; the mask still tracks occupancy.
    assign scan_mask = mask_w | {BIN_N{1'b1}};
`endif

    huff_next_bin #(
        .SYM_W (SYM_W)
    ) u_next_bin (
        .mask       (scan_mask),
        .ptr        (ptr_reg),
        .idx        (next_idx),
        .found      (next_found),
        .none_after (next_none_after)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= COUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake decode and next-state logic
    always_comb begin
        state_next = state_reg;
        in_fire    = (state_reg == COUNT) && bus.in_valid;
        node_fire  = node_valid_reg && bus.node_ready;
        block_done = node_fire && node_last_reg;
        // Load into an empty register or behind a node leaving this cycle
        load_node  = (state_reg == EMIT) && next_found && !block_done &&
                     (!node_valid_reg || bus.node_ready);
        case (state_reg)
            COUNT: if (in_fire && bus.in_last) state_next = EMIT;
            EMIT:  if (block_done)             state_next = COUNT;
            default: state_next = COUNT;
        endcase
    end

    // One saturating counter and occupancy bit per symbol bin
    generate
        for (genvar gi = 0; gi < BIN_N; gi++) begin : g_bin
            logic [CNT_W-1:0] weight_reg;
            logic             occupied_reg;
            logic             hit;
            logic             clr;

            assign hit = in_fire && (bus.in_sym == SYM_W'(gi));
            assign clr = load_node && (next_idx == SYM_W'(gi));

            // Count in COUNT; read-and-clear when this bin is emitted
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    weight_reg   <= '0;
                    occupied_reg <= 1'b0;
                end else if (clr) begin
                    weight_reg   <= '0;
                    occupied_reg <= 1'b0;
                end else if (hit) begin
                    if (weight_reg != CNT_MAX) begin
                        weight_reg <= weight_reg + CNT_W'(1);
                    end
                    occupied_reg <= 1'b1;
                end
            end

            assign bin_w[gi]  = weight_reg;
            assign mask_w[gi] = occupied_reg;
        end
    endgenerate

    // Output register, scan pointer and per-block node counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            node_reg       <= '0;
            node_valid_reg <= 1'b0;
            node_last_reg  <= 1'b0;
            node_cnt_reg   <= '0;
            ptr_reg        <= '0;
        end else begin
            if (load_node) begin
                node_reg       <= {bin_w[next_idx], next_idx};
                node_valid_reg <= 1'b1;
                node_last_reg  <= next_none_after;
                node_cnt_reg   <= node_cnt_reg + (SYM_W+1)'(1);
                ptr_reg        <= {1'b0, next_idx} + (SYM_W+1)'(1);
            end else if (node_fire) begin
                node_valid_reg <= 1'b0;
                node_last_reg  <= 1'b0;
            end
            if (block_done) begin
                ptr_reg <= '0;
            end
            if (in_fire && bus.in_last) begin
                node_cnt_reg <= '0;
            end
        end
    end

    assign bus.in_ready   = (state_reg == COUNT);
    assign bus.node_valid = node_valid_reg;
    assign bus.node       = node_reg;
    assign bus.node_last  = node_last_reg;
    assign bus.node_cnt   = node_cnt_reg;

endmodule

// File: tb/tb_huff_freq_count.sv
// Self-checking bench for huff_freq_count: directed scenarios plus random
// blocks, all checked against a histogram model built from plain counts.
module tb_huff_freq_count;

`ifdef HUFF_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef logic [7:0] node_q_t[$];
    typedef logic [3:0] sym_q_t[$];

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    huff_freq_count_if bus();

    huff_freq_count dut (
        .CLK  (clk),
        .nRST (n_rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: histogram of the block, one node per bin in symbol order
    function automatic node_q_t model(input sym_q_t syms);
        int hist[16];
        node_q_t q;
        logic [3:0] w;
        foreach (hist[i]) hist[i] = 0;
        foreach (syms[i]) hist[syms[i]]++;
        for (int s = 0; s < 16; s++) begin
            if (SKIP && hist[s] == 0) continue;
            w = (hist[s] > 15) ? 4'hF : hist[s][3:0];
            q.push_back({w, s[3:0]});
        end
        return q;
    endfunction

    task automatic send_block(input sym_q_t syms, input string tag);
        for (int i = 0; i < syms.size(); i++) begin
            int wait_c = 0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sym   = syms[i];
            bus.in_last  = (i == syms.size() - 1);
            while (bus.in_ready !== 1'b1 && wait_c < 100) begin
                @(negedge clk);
                wait_c++;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready_wait: got %b want 1", tag, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic collect(input node_q_t exp, input bit rnd_ready, input string tag);
        int k = 0;
        int cycles = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_node = '0;
        while (k < exp.size() && cycles < 400) begin
            @(negedge clk);
            cycles++;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s emit_in_ready: got %b want 0", tag, bus.in_ready);
            end
            if (prev_stall) begin
                checks++;
                if (bus.node_valid !== 1'b1 || bus.node !== prev_node) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b %02h want v=1 %02h",
                             tag, bus.node_valid, bus.node, prev_node);
                end
            end
            bus.node_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_stall = 1'b0;
            if (bus.node_valid === 1'b1) begin
                if (bus.node_ready) begin
                    $display("%s node %0d = %02h last=%b cnt=%0d", tag, k, bus.node,
                             bus.node_last, bus.node_cnt);
                    checks += 3;
                    if (bus.node !== exp[k]) begin
                        errors++;
                        $display("FAIL %s node[%0d]: got %02h want %02h", tag, k, bus.node, exp[k]);
                    end
                    if (bus.node_last !== (k == exp.size() - 1)) begin
                        errors++;
                        $display("FAIL %s node_last[%0d]: got %b want %b", tag, k,
                                 bus.node_last, (k == exp.size() - 1));
                    end
                    if (bus.node_cnt !== 5'(k + 1)) begin
                        errors++;
                        $display("FAIL %s node_cnt[%0d]: got %0d want %0d", tag, k, bus.node_cnt, k + 1);
                    end
                    k++;
                end else begin
                    prev_stall = 1'b1;
                    prev_node  = bus.node;
                end
            end
        end
        checks++;
        if (k < exp.size()) begin
            errors++;
            $display("FAIL %s node_timeout: got %0d nodes want %0d", tag, k, exp.size());
        end
        @(negedge clk);
        checks++;
        if (bus.node_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s block_end: got v=%b rdy=%b want v=0 rdy=1", tag,
                     bus.node_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            checks += 5;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
            if (bus.node_valid !== 1'b0) begin errors++; $display("FAIL reset node_valid: got %b want 0", bus.node_valid); end
            if (bus.node !== 8'h00) begin errors++; $display("FAIL reset node: got %02h want 00", bus.node); end
            if (bus.node_last !== 1'b0) begin errors++; $display("FAIL reset node_last: got %b want 0", bus.node_last); end
            if (bus.node_cnt !== 5'd0) begin errors++; $display("FAIL reset node_cnt: got %0d want 0", bus.node_cnt); end
            n_rst = 1'b1;
            $display("reset pass %0d checked", pass);
        end
    endtask

    task automatic test_basic();
        sym_q_t syms = '{4'd3, 4'd3, 4'd5};
        node_q_t exp = model(syms);
        bus.node_ready = 1'b0;
        send_block(syms, "basic");
        @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic in_ready_after_last: got %b want 0", bus.in_ready); end
        if (bus.node_valid !== 1'b0) begin errors++; $display("FAIL basic early_node_valid: got %b want 0", bus.node_valid); end
        @(negedge clk);
        checks += 2;
        if (bus.node_valid !== 1'b1) begin errors++; $display("FAIL basic first_node_valid: got %b want 1", bus.node_valid); end
        if (bus.node !== exp[0]) begin errors++; $display("FAIL basic first_node: got %02h want %02h", bus.node, exp[0]); end
        collect(exp, 1'b0, "basic");
    endtask

    task automatic test_saturate();
        sym_q_t syms;
        for (int i = 0; i < 20; i++) syms.push_back(4'hA);
        send_block(syms, "saturate");
        collect(model(syms), 1'b0, "saturate");
    endtask

    task automatic test_backpressure();
        sym_q_t syms = '{4'd1, 4'd2};
        node_q_t exp = model(syms);
        int wait_c = 0;
        bus.node_ready = 1'b0;
        send_block(syms, "bp");
        while (bus.node_valid !== 1'b1 && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.node_valid !== 1'b1 || bus.node !== exp[0]) begin
                errors++;
                $display("FAIL bp hold[%0d]: got v=%b %02h want v=1 %02h", c, bus.node_valid, bus.node, exp[0]);
            end
        end
        collect(exp, 1'b0, "bp");
    endtask

    task automatic test_reset_mid_emit();
        sym_q_t syms = '{4'd3, 4'd7, 4'd9};
        sym_q_t syms2 = '{4'd7};
        int wait_c = 0;
        bus.node_ready = 1'b1;
        send_block(syms, "midrst");
        @(negedge clk);
        while (bus.node_valid !== 1'b1 && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        checks += 3;
        if (bus.node_valid !== 1'b0) begin errors++; $display("FAIL midrst node_valid: got %b want 0", bus.node_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready: got %b want 1", bus.in_ready); end
        if (bus.node_cnt !== 5'd0) begin errors++; $display("FAIL midrst node_cnt: got %0d want 0", bus.node_cnt); end
        @(negedge clk);
        n_rst = 1'b1;
        send_block(syms2, "after_rst");
        collect(model(syms2), 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        sym_q_t syms = '{4'd4};
        node_q_t exp = model(syms);
        int n = exp.size();
        int in_hs[$];
        int last_hs[$];
        int k = 0;
        bus.node_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sym   = 4'd4;
        bus.in_last  = 1'b1;
        for (int cyc = 0; cyc < 120 && last_hs.size() < 2; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.in_ready === 1'b1) in_hs.push_back(cyc);
            if (bus.node_valid === 1'b1) begin
                checks += 2;
                if (bus.node !== exp[k % n]) begin
                    errors++;
                    $display("FAIL b2b node[%0d]: got %02h want %02h", k, bus.node, exp[k % n]);
                end
                if (bus.node_last !== ((k % n) == n - 1)) begin
                    errors++;
                    $display("FAIL b2b node_last[%0d]: got %b want %b", k, bus.node_last, ((k % n) == n - 1));
                end
                if ((k % n) == n - 1) last_hs.push_back(cyc);
                $display("b2b node %0d = %02h at cycle %0d", k, bus.node, cyc);
                k++;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks += 2;
        if (last_hs.size() != 2) begin
            errors++;
            $display("FAIL b2b block_count: got %0d want 2", last_hs.size());
        end else if (in_hs.size() < 2 || in_hs[1] != last_hs[0] + 1) begin
            errors++;
            $display("FAIL b2b restart_cycle: got %0d want %0d",
                     (in_hs.size() < 2) ? -1 : in_hs[1], last_hs[0] + 1);
        end
        if (in_hs.size() < 1 || in_hs[0] != 0) begin
            errors++;
            $display("FAIL b2b first_accept: got %0d want 0", (in_hs.size() < 1) ? -1 : in_hs[0]);
        end
        @(negedge clk);
        checks++;
        if (bus.node_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b idle: got v=%b rdy=%b want v=0 rdy=1", bus.node_valid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            sym_q_t syms;
            int len = $urandom_range(1, 40);
            int base = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                if (b[0]) syms.push_back(4'($urandom_range(0, 15)));
                else      syms.push_back(4'(base + $urandom_range(0, 3)));
            end
            $display("random block %0d len %0d", b, len);
            send_block(syms, "random");
            collect(model(syms), 1'b1, "random");
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sym     = '0;
        bus.in_last    = 1'b0;
        bus.node_ready = 1'b0;
        n_rst          = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_reset_mid_emit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
